// File: rtl/sram_arb_controller.sv
// Single-port async SRAM controller: N_RD round-robin read clients and one write client,
// with write/read alternation so neither side can starve the other.
module sram_arb_controller #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int N_RD    = 2,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input  logic                     clk_100m,
    input  logic                     rst_n,
    inout  wire  [DATA_W-1:0]        ram_data,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_ce_n,
    output logic                     ram_oe_n,
    output logic                     ram_we_n,
    input  logic [N_RD-1:0]          rd_req,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD-1:0]          rd_ack,
    output logic [N_RD-1:0]          rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack
);

    localparam int PTR_W   = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam int CNT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [PTR_W:0] N_RD_EXT = (PTR_W+1)'(N_RD);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  rr_ptr;
    logic              last_wr;
    logic              drv_en;
    logic [DATA_W-1:0] wr_data_q;
    logic [N_RD-1:0]   rd_cur;

    // Round-robin search results, valid only while state is IDLE.
    logic              rd_found;
    logic [PTR_W-1:0]  rd_sel;
    logic [PTR_W-1:0]  rd_nxt_ptr;
    logic [N_RD-1:0]   rd_sel_oh;
    logic [ADDR_W-1:0] rd_sel_addr;
    logic [N_RD-1:0]   req_rot;
    logic [PTR_W:0]    sum_sel;
    logic [PTR_W:0]    sum_nxt;

    logic              wr_win;

    assign ram_data = drv_en ? wr_data_q : {DATA_W{1'bz}};

    // A write may not win twice in a row while any read is waiting.
    assign wr_win = wr_req && (!last_wr || (rd_req == '0));

    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment so
        // no path leaves a value held, which would otherwise infer a latch.
        rd_found    = 1'b0;
        rd_sel      = '0;
        rd_nxt_ptr  = '0;
        rd_sel_oh   = '0;
        rd_sel_addr = '0;
        sum_sel     = '0;
        sum_nxt     = '0;

        // Rotate so bit 0 is the channel at rr_ptr; the first set bit wins.
        req_rot = N_RD'({rd_req, rd_req} >> rr_ptr);
        for (int k = 0; k < N_RD; k++) begin
            if (!rd_found && req_rot[k]) begin
                rd_found = 1'b1;
                sum_sel  = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (sum_sel >= N_RD_EXT) begin
                    sum_sel = sum_sel - N_RD_EXT;
                end
                rd_sel = PTR_W'(sum_sel);
            end
        end

        for (int k = 0; k < N_RD; k++) begin
            if (rd_sel == PTR_W'(k)) begin
                rd_sel_oh[k] = 1'b1;
                rd_sel_addr  = rd_addr[k*ADDR_W +: ADDR_W];
            end
        end

        sum_nxt = {1'b0, rd_sel} + (PTR_W+1)'(1);
        if (sum_nxt >= N_RD_EXT) begin
            sum_nxt = '0;
        end
        rd_nxt_ptr = PTR_W'(sum_nxt);
    end

    always_ff @(posedge clk_100m) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            last_wr   <= 1'b0;
            drv_en    <= 1'b0;
            wr_data_q <= '0;
            rd_cur    <= '0;
            ram_addr  <= '0;
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            rd_ack    <= '0;
            rd_valid  <= '0;
            rd_data   <= '0;
            wr_ack    <= 1'b0;
        end else begin
            ram_ce_n <= 1'b0;
            rd_ack   <= '0;
            rd_valid <= '0;
            wr_ack   <= 1'b0;

            case (state)
                IDLE: begin
                    if (wr_win) begin
                        ram_addr  <= wr_addr;
                        wr_data_q <= wr_data;
                        drv_en    <= 1'b1;
                        wr_ack    <= 1'b1;
                        last_wr   <= 1'b1;
                        state     <= WR_SETUP;
                    end else if (rd_found) begin
                        ram_addr <= rd_sel_addr;
                        ram_oe_n <= 1'b0;
                        rd_ack   <= rd_sel_oh;
                        rd_cur   <= rd_sel_oh;
                        rr_ptr   <= rd_nxt_ptr;
                        last_wr  <= 1'b0;
                        cnt      <= CNT_W'(RD_WAIT - 1);
                        state    <= RD;
                    end
                end

                RD: begin
                    if (cnt == '0) begin
                        rd_data  <= ram_data;
                        rd_valid <= rd_cur;
                        ram_oe_n <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                // Address and data were set up one cycle before we_n falls.
                WR_SETUP: begin
                    ram_we_n <= 1'b0;
                    cnt      <= CNT_W'(WR_WAIT - 1);
                    state    <= WR_PULSE;
                end

                WR_PULSE: begin
                    if (cnt == '0) begin
                        ram_we_n <= 1'b1;
                        state    <= WR_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                // Keep driving one cycle past the rising we_n for data hold time.
                WR_HOLD: begin
                    drv_en <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arb_controller.sv
// Self-checking bench for sram_arb_controller: directed scenarios then randomized request
// patterns, checked against a grant-order/memory reference model and a behavioural SRAM.
module tb_sram_arb_controller;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 32;
    localparam int N_RD    = 2;
    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 1;

    logic                   clk_100m;
    logic                   rst_n;
    wire  [DATA_W-1:0]      ram_data;
    logic [ADDR_W-1:0]      ram_addr;
    logic                   ram_ce_n;
    logic                   ram_oe_n;
    logic                   ram_we_n;
    logic [N_RD-1:0]        rd_req;
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD-1:0]        rd_ack;
    logic [N_RD-1:0]        rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic                   wr_req;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   wr_ack;

    sram_arb_controller #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .N_RD    (N_RD),
        .RD_WAIT (RD_WAIT),
        .WR_WAIT (WR_WAIT)
    ) dut (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_ce_n (ram_ce_n),
        .ram_oe_n (ram_oe_n),
        .ram_we_n (ram_we_n),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ack   (rd_ack),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack)
    );

    initial clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;

    // Behavioural async SRAM (256 words), with a preload port used during reset.
    logic [DATA_W-1:0] sram [0:255];
    logic              mdl_load;
    logic [7:0]        mdl_load_addr;
    logic [DATA_W-1:0] mdl_load_data;

    assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n) ? sram[ram_addr[7:0]] : {DATA_W{1'bz}};

    always @(posedge clk_100m) begin
        if (mdl_load) begin
            sram[mdl_load_addr] <= mdl_load_data;
        end else if (!ram_ce_n && !ram_we_n) begin
            sram[ram_addr[7:0]] <= ram_data;
        end
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [0:255];
    int                m_rr;
    logic              m_last_wr;
    logic [DATA_W-1:0] m_rd_data;

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
        int                gcyc;
    } rd_exp_t;

    rd_exp_t           rq[$];
    int                glog[$];
    int                n_cmp;
    int                n_mis;
    int                cyc;
    int                prev_gcyc;
    int                prev_gtype;
    int                run_start;
    logic [ADDR_W-1:0] w_addr_exp;
    logic [DATA_W-1:0] w_data_exp;
    logic              w_active;
    int                w_low;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100m);
        #1;
        cyc++;
    endtask

    // Grant rule: write wins unless it won last time and a read waits; otherwise the
    // first requesting channel at or after the round-robin pointer.
    function automatic int model_grant(input logic w, input logic [N_RD-1:0] r);
        if (w && (!m_last_wr || r == '0)) begin
            m_last_wr = 1'b1;
            return -1;
        end
        for (int k = 0; k < N_RD; k++) begin
            int c;
            c = (m_rr + k) % N_RD;
            if (r[c]) begin
                m_rr      = (c + 1) % N_RD;
                m_last_wr = 1'b0;
                return c;
            end
        end
        return -2;
    endfunction

    task automatic observe(input bit hold);
        int      obs_g;
        rd_exp_t e;

        if (ram_we_n == 1'b0) begin
            w_low++;
            check("we_addr", 64'(ram_addr), 64'(w_addr_exp));
            check("we_data", 64'(ram_data), 64'(w_data_exp));
            check("we_oe_hi", 64'(ram_oe_n), 64'd1);
        end else if (w_active && w_low > 0) begin
            check("we_len", 64'(w_low), 64'(WR_WAIT));
            w_active = 1'b0;
        end

        if (ram_oe_n == 1'b0) begin
            check("rd_bus", 64'(ram_data), 64'(sram[ram_addr[7:0]]));
        end

        if (wr_ack || rd_ack != '0) begin
            check("grant_cnt", 64'($countones({wr_ack, rd_ack})), 64'd1);
            obs_g = -2;
            if (wr_ack) begin
                obs_g = -1;
            end else begin
                for (int k = 0; k < N_RD; k++) begin
                    if (rd_ack[k] && obs_g == -2) obs_g = k;
                end
            end
            check("grant", 64'(obs_g), 64'(model_grant(wr_req, rd_req)));
            if (prev_gcyc >= 0) begin
                check("grant_gap", 64'(cyc - prev_gcyc),
                      64'((prev_gtype == -1) ? WR_WAIT + 3 : RD_WAIT + 1));
            end else begin
                check("first_lat", 64'(cyc - run_start), 64'd1);
            end
            prev_gcyc  = cyc;
            prev_gtype = obs_g;
            glog.push_back(obs_g);

            if (obs_g == -1) begin
                check("wr_addr_bus", 64'(ram_addr), 64'(wr_addr));
                w_addr_exp = wr_addr;
                w_data_exp = wr_data;
                w_active   = 1'b1;
                w_low      = 0;
                ref_mem[wr_addr[7:0]] = wr_data;
                if (!hold) wr_req = 1'b0;
            end else if (obs_g >= 0) begin
                check("rd_addr_bus", 64'(ram_addr), 64'(rd_addr[obs_g*ADDR_W +: ADDR_W]));
                check("rd_oe_lo", 64'(ram_oe_n), 64'd0);
                e.ch   = obs_g;
                e.data = ref_mem[rd_addr[obs_g*ADDR_W +: 8]];
                e.gcyc = cyc;
                rq.push_back(e);
                if (!hold) rd_req[obs_g] = 1'b0;
            end
        end

        if (rd_valid != '0) begin
            if (rq.size() == 0) begin
                check("spurious_valid", 64'(rd_valid), 64'd0);
            end else begin
                e = rq.pop_front();
                check("rd_valid", 64'(rd_valid), 64'd1 << e.ch);
                check("rd_data", 64'(rd_data), 64'(e.data));
                check("rd_lat", 64'(cyc - e.gcyc), 64'(RD_WAIT));
                m_rd_data = e.data;
            end
        end else begin
            check("rd_hold", 64'(rd_data), 64'(m_rd_data));
        end
    endtask

    // Present a request pattern; with hold=1 clients re-request after each ack until
    // n grants have been seen, otherwise each client drops after its own ack.
    task automatic run(input logic w, input logic [N_RD-1:0] r, input bit hold, input int n);
        int budget;
        budget    = 0;
        prev_gcyc = -1;
        run_start = cyc;
        glog.delete();
        wr_req = w;
        rd_req = r;
        while (budget < 300) begin
            tick();
            observe(hold);
            budget++;
            if (hold && glog.size() >= n) begin
                wr_req = 1'b0;
                rd_req = '0;
            end
            if (!wr_req && rd_req == '0 && rq.size() == 0 && !w_active) break;
        end
        check("run_timeout", 64'(budget < 300), 64'd1);
        repeat (WR_WAIT + 3) begin
            tick();
            observe(1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got;
        n_cmp = 0; n_mis = 0; cyc = 0;
        rst_n = 1'b0; wr_req = 1'b0; rd_req = '0; rd_addr = '0;
        wr_addr = '0; wr_data = '0; mdl_load = 1'b0;
        mdl_load_addr = '0; mdl_load_data = '0;
        w_active = 1'b0; w_low = 0; w_addr_exp = '0; w_data_exp = '0;
        prev_gcyc = -1; prev_gtype = 0; run_start = 0;

        // Preload the SRAM model while reset is held.
        for (int i = 0; i < 256; i++) begin
            mdl_load      = 1'b1;
            mdl_load_addr = 8'(i);
            mdl_load_data = (i == 16) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i) * 32'h0101;
            ref_mem[i]    = mdl_load_data;
            tick();
        end
        mdl_load = 1'b0;

        repeat (5) tick();
        check("rst_ce_n", 64'(ram_ce_n), 64'd1);
        check("rst_oe_n", 64'(ram_oe_n), 64'd1);
        check("rst_we_n", 64'(ram_we_n), 64'd1);
        check("rst_addr", 64'(ram_addr), 64'd0);
        check("rst_rd_ack", 64'(rd_ack), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_wr_ack", 64'(wr_ack), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);

        m_rr = 0; m_last_wr = 1'b0; m_rd_data = '0;
        rst_n = 1'b1;
        tick();
        check("rel_ce_n", 64'(ram_ce_n), 64'd0);
        check("rel_oe_n", 64'(ram_oe_n), 64'd1);
        check("rel_we_n", 64'(ram_we_n), 64'd1);

        // Single read on channel 1.
        rd_addr[ADDR_W +: ADDR_W] = 20'h00010;
        run(1'b0, 2'b10, 1'b0, 1);
        check("single_rd_data", 64'(rd_data), 64'hDEADBEEF);
        check("single_rd_ch", 64'(glog.size() > 0 ? glog[0] : -9), 64'd1);

        // Single write, then read it back on channel 0.
        wr_addr = 20'h00020;
        wr_data = 32'h12345678;
        run(1'b1, '0, 1'b0, 1);
        check("sram_0x20", 64'(sram[8'h20]), 64'h12345678);
        rd_addr[0 +: ADDR_W] = 20'h00020;
        run(1'b0, 2'b01, 1'b0, 1);
        check("readback_0x20", 64'(rd_data), 64'h12345678);

        // Round-robin with both channels requesting continuously.
        rd_addr[ADDR_W +: ADDR_W] = 20'h00010;
        run(1'b0, 2'b11, 1'b1, 4);
        check("rr_n", 64'(glog.size()), 64'd4);
        check("rr_alt1", 64'(glog[1]), 64'((glog[0] + 1) % 2));
        check("rr_alt2", 64'(glog[2]), 64'(glog[0]));

        // Fairness: write and read channel 0 requesting continuously.
        wr_addr = 20'h00030;
        wr_data = 32'hCAFEF00D;
        rd_addr[0 +: ADDR_W] = 20'h00030;
        run(1'b1, 2'b01, 1'b1, 4);
        check("fair_n", 64'(glog.size()), 64'd4);
        check("fair_g0", 64'(glog[0]), 64'(-1));
        check("fair_g1", 64'(glog[1]), 64'd0);
        check("fair_g2", 64'(glog[2]), 64'(-1));
        check("fair_g3", 64'(glog[3]), 64'd0);
        check("fair_data", 64'(rd_data), 64'hCAFEF00D);

        // Reset during the write pulse drops the write.
        wr_addr = 20'h000F0;
        wr_data = 32'hBAD0BAD0;
        wr_req  = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (wr_ack) got = 1'b1;
        end
        check("mwr_ack", 64'(got), 64'd1);
        wr_req = 1'b0;
        tick();
        check("mwr_pulse", 64'(ram_we_n), 64'd0);
        rst_n = 1'b0;
        tick();
        check("mwr_we_n", 64'(ram_we_n), 64'd1);
        check("mwr_oe_n", 64'(ram_oe_n), 64'd1);
        check("mwr_ce_n", 64'(ram_ce_n), 64'd1);
        check("mwr_wr_ack", 64'(wr_ack), 64'd0);
        check("mwr_addr", 64'(ram_addr), 64'd0);
        check("mwr_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        m_rr = 0; m_last_wr = 1'b0; m_rd_data = '0; w_active = 1'b0; w_low = 0;
        tick();
        check("mwr_rel_ce_n", 64'(ram_ce_n), 64'd0);
        repeat (4) begin
            tick();
            check("mwr_no_ack", 64'(wr_ack), 64'd0);
            check("mwr_we_idle", 64'(ram_we_n), 64'd1);
        end
        rd_addr[0 +: ADDR_W] = 20'h00020;
        run(1'b0, 2'b01, 1'b0, 1);
        check("mwr_readback", 64'(rd_data), 64'h12345678);

        // Randomized request patterns.
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < N_RD; c++) begin
                rd_addr[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 63));
            end
            wr_addr = ADDR_W'($urandom_range(0, 63));
            wr_data = $urandom;
            run(1'($urandom_range(0, 1)), N_RD'($urandom), ($urandom_range(0, 3) == 0),
                $urandom_range(2, 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
